seq_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Single-cycle operations: the existing logic/arith/shift set plus XOR, SRA and SLTU. All results are registered.
- Multi-cycle operations: iterative signed/unsigned multiply and divide writing HI/LO registers.
- Sits in the EX stage; the stall logic uses busy/done.

---
 rtl/seq_alu.sv | 212 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative signed/unsigned multiply and divide that write the HI/LO pair.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluControlOp,
  input  logic             aluSrc,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_count;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;

  logic [WIDTH-1:0]   w_opb;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_opb    = aluSrc ? imm : rtData;
  assign w_is_mul = (aluControlOp == OP_MULT) || (aluControlOp == OP_MULTU);
  assign w_is_div = (aluControlOp == OP_DIV)  || (aluControlOp == OP_DIVU);
  assign w_signed = (aluControlOp == OP_MULT) || (aluControlOp == OP_DIV);
  assign w_a_neg  = w_signed & rsData[WIDTH-1];
  assign w_b_neg  = w_signed & w_opb[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -rsData : rsData;
  assign w_b_mag  = w_b_neg ? -w_opb : w_opb;

  always_comb begin
    w_alu = '0;
    case (aluControlOp)
      OP_AND:  w_alu = rsData & w_opb;
      OP_OR:   w_alu = rsData | w_opb;
      OP_ADD:  w_alu = rsData + w_opb;
      OP_XOR:  w_alu = rsData ^ w_opb;
      OP_SLL:  w_alu = rtData << shamt;
      OP_SUB:  w_alu = rsData - w_opb;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(rsData) < $signed(w_opb))};
      OP_SRL:  w_alu = rtData >> shamt;
      OP_SRA:  w_alu = $signed(rtData) >>> shamt;
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (rsData < w_opb)};
      OP_NOR:  w_alu = ~(rsData | w_opb);
      default: w_alu = '0;
    endcase
  end

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mag} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
  // The partial remainder stays below the divisor, so bit WIDTH of the
  // difference is a clean borrow flag.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_mag};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_mag    <= w_a_mag;
              r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= 1'b0;
              r_is_div <= 1'b0;
              r_count  <= '0;
              r_busy   <= 1'b1;
              r_state  <= MUL;
            end else if (w_is_div && (w_opb == '0)) begin
              r_hi     <= rsData;
              r_lo     <= '1;
              r_result <= '1;
              r_dbz    <= 1'b1;
              r_done   <= 1'b1;
            end else if (w_is_div) begin
              r_mag    <= w_b_mag;
              r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= w_a_neg;
              r_is_div <= 1'b1;
              r_count  <= '0;
              r_busy   <= 1'b1;
              r_state  <= DIV;
            end else begin
              r_result <= w_alu;
              r_done   <= 1'b1;
            end
          end
        end
        MUL: begin
          r_acc   <= w_mul_next;
          r_count <= r_count + 1'b1;
          if (r_count == SHW'(WIDTH-1)) r_state <= FIN;
        end
        DIV: begin
          r_acc   <= w_div_next;
          r_count <= r_count + 1'b1;
          if (r_count == SHW'(WIDTH-1)) r_state <= FIN;
        end
        FIN: begin
          if (r_is_div) begin
            r_hi     <= w_rem_fix;
            r_lo     <= w_quo_fix;
            r_result <= w_quo_fix;
          end else begin
            r_hi     <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo     <= w_prod_fix[WIDTH-1:0];
            r_result <= w_prod_fix[WIDTH-1:0];
          end
          r_count <= '0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign divByZero = r_dbz;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance driven with
// directed and random operations, checked against an arithmetic reference.
module tb_seq_alu;

  typedef longint unsigned u64;
  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        s_start, s_src, s_busy, s_done, s_dbz;
  logic [3:0]  s_op;
  logic [31:0] s_rs, s_rt, s_imm, s_result, s_hi, s_lo;
  logic [4:0]  s_sh;

  logic        e_start, e_src, e_busy, e_done, e_dbz;
  logic [3:0]  e_op;
  logic [7:0]  e_rs, e_rt, e_imm, e_result, e_hi, e_lo;
  logic [2:0]  e_sh;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .aluControlOp(s_op), .aluSrc(s_src),
    .rsData(s_rs), .rtData(s_rt), .shamt(s_sh), .imm(s_imm),
    .result(s_result), .hi(s_hi), .lo(s_lo), .busy(s_busy), .done(s_done), .divByZero(s_dbz)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(e_start), .aluControlOp(e_op), .aluSrc(e_src),
    .rsData(e_rs), .rtData(e_rt), .shamt(e_sh), .imm(e_imm),
    .result(e_result), .hi(e_hi), .lo(e_lo), .busy(e_busy), .done(e_done), .divByZero(e_dbz)
  );

  exp_t q32[$];
  exp_t q8[$];
  u64   m_hi[2];
  u64   m_lo[2];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input u64 x, input int w);
    u64     m = (64'd1 << w) - 64'd1;
    longint v = longint'(x & m);
    if (((x >> (w - 1)) & 64'd1) != 64'd0) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: plain integer arithmetic on sign-extended values.
  function automatic void model(input int sel, input int w, input logic [3:0] op,
                                input u64 a_in, input u64 b_in, input u64 rt_in,
                                input int sh, output exp_t e, output int lat);
    u64     m  = (64'd1 << w) - 64'd1;
    u64     a  = a_in & m;
    u64     b  = b_in & m;
    u64     rt = rt_in & m;
    u64     r  = 64'd0;
    u64     p;
    longint sa = sx(a, w);
    longint sb = sx(b, w);
    bit     md = 1'b0;
    e.dbz = 1'b0;
    lat   = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = rt << sh;
      4'd6:  r = a - b;
      4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  r = rt >> sh;
      4'd9:  r = u64'(sx(rt, w) >>> sh);
      4'd10: r = (a < b) ? 64'd1 : 64'd0;
      4'd12: r = ~(a | b);
      4'd13: begin p = u64'(sa * sb); m_hi[sel] = (p >> w) & m; m_lo[sel] = p & m; lat = w + 1; md = 1'b1; end
      4'd14: begin p = a * b;         m_hi[sel] = (p >> w) & m; m_lo[sel] = p & m; lat = w + 1; md = 1'b1; end
      4'd11, 4'd15: begin
        md = 1'b1;
        if (b == 64'd0) begin
          m_hi[sel] = a; m_lo[sel] = m; e.dbz = 1'b1;
        end else if (op == 4'd15) begin
          m_lo[sel] = u64'(sa / sb) & m; m_hi[sel] = u64'(sa % sb) & m; lat = w + 1;
        end else begin
          m_lo[sel] = (a / b) & m; m_hi[sel] = (a % b) & m; lat = w + 1;
        end
      end
      default: r = 64'd0;
    endcase
    if (md) r = m_lo[sel];
    e.res = 32'(r & m);
    e.hi  = 32'(m_hi[sel]);
    e.lo  = 32'(m_lo[sel]);
    e.due = 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic issue(input int sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] rt, input logic [31:0] imm, input bit src, input int sh);
    exp_t e;
    int   lat;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (((sel == 0) ? s_busy : e_busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", guard);
    end
    model(sel, (sel == 0) ? 32 : 8, op, u64'(a), u64'(src ? imm : rt), u64'(rt), sh, e, lat);
    e.due = cyc + 1 + lat;
    if (sel == 0) begin
      s_op = op; s_rs = a; s_rt = rt; s_imm = imm; s_src = src; s_sh = 5'(sh); s_start = 1'b1;
      q32.push_back(e);
    end else begin
      e_op = op; e_rs = a[7:0]; e_rt = rt[7:0]; e_imm = imm[7:0]; e_src = src; e_sh = 3'(sh); e_start = 1'b1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    s_start = 1'b0;
    e_start = 1'b0;
  endtask

  task automatic on_done(input int sel, input logic [31:0] res, input logic [31:0] h,
                         input logic [31:0] l, input logic dbz, input logic bsy);
    exp_t e;
    if ((sel == 0 && q32.size() == 0) || (sel == 1 && q8.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done w%0d: done=1 with nothing outstanding at cycle %0d, expected done=0",
               (sel == 0) ? 32 : 8, cyc);
      return;
    end
    if (sel == 0) e = q32.pop_front();
    else          e = q8.pop_front();
    $display("done w=%0d cyc=%0d result=%h hi=%h lo=%h dbz=%0d", (sel == 0) ? 32 : 8, cyc, res, h, l, dbz);
    chk("result", res, e.res);
    chk("hi", h, e.hi);
    chk("lo", l, e.lo);
    chk("divByZero", {31'b0, dbz}, {31'b0, e.dbz});
    chk("busy_at_done", {31'b0, bsy}, 32'd0);
    chk("latency", 32'(cyc), 32'(e.due));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_done) on_done(0, s_result, s_hi, s_lo, s_dbz, s_busy);
      if (e_done) on_done(1, {24'b0, e_result}, {24'b0, e_hi}, {24'b0, e_lo}, e_dbz, e_busy);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_result"}, s_result, 32'd0);
    chk({tag, "_hi"}, s_hi, 32'd0);
    chk({tag, "_lo"}, s_lo, 32'd0);
    chk({tag, "_flags"}, {29'b0, s_busy, s_done, s_dbz}, 32'd0);
    chk({tag, "_w8"}, {e_result, e_hi, e_lo, 5'b0, e_busy, e_done, e_dbz}, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, rt, imm;
    bit          src;
    int          guard;
    s_start = 0; s_op = 0; s_src = 0; s_rs = 0; s_rt = 0; s_imm = 0; s_sh = 0;
    e_start = 0; e_op = 0; e_src = 0; e_rs = 0; e_rt = 0; e_imm = 0; e_sh = 0;
    for (int i = 0; i < 2; i++) begin m_hi[i] = 0; m_lo[i] = 0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed, 32-bit
    issue(0, 4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 0);
    issue(0, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 0);
    issue(0, 4'b1010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 0);
    issue(0, 4'b0010, 32'd3, 32'd0, 32'hFFFFFFFE, 1'b1, 0);
    issue(0, 4'b1101, 32'hFFFFFFFD, 32'd7, 32'd0, 1'b0, 0);
    issue(0, 4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
    issue(0, 4'b1011, 32'd100, 32'd7, 32'd0, 1'b0, 0);
    issue(0, 4'b1111, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 0);
    issue(0, 4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
    issue(0, 4'b1111, 32'd9, 32'd0, 32'd0, 1'b0, 0);
    issue(0, 4'b0101, 32'd9, 32'd3, 32'd0, 1'b0, 0);
    issue(0, 4'b1001, 32'd0, 32'h80000000, 32'd0, 1'b0, 4);

    // Start while busy must be ignored
    issue(0, 4'b1101, 32'd123, 32'hFFFFFE38, 32'd0, 1'b0, 0);
    @(negedge clk); @(negedge clk);
    s_op = 4'b0010; s_rs = 32'd1; s_rt = 32'd1; s_src = 1'b0; s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;

    // Random, 32-bit
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; rt = $urandom; imm = $urandom;
      src = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin rt = 0; imm = 0; end
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      issue(0, op, a, rt, imm, src, $urandom_range(0, 31));
    end

    // Reset in the middle of a multiply
    issue(0, 4'b1101, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #2;
    chk("busy_mid_mult", {31'b0, s_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q32.delete();
    q8.delete();
    for (int i = 0; i < 2; i++) begin m_hi[i] = 0; m_lo[i] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 4'b0010, 32'd1, 32'd1, 32'd0, 1'b0, 0);

    // Directed and random, 8-bit
    issue(1, 4'b1110, 32'hFF, 32'h02, 32'd0, 1'b0, 0);
    issue(1, 4'b1001, 32'd0, 32'h80, 32'd0, 1'b0, 3);
    issue(1, 4'b1111, 32'h80, 32'hFF, 32'd0, 1'b0, 0);
    issue(1, 4'b1111, 32'hF9, 32'h02, 32'd0, 1'b0, 0);
    issue(1, 4'b1011, 32'h33, 32'h00, 32'd0, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; rt = $urandom; imm = $urandom;
      src = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin rt = 0; imm = 0; end
      if ($urandom_range(0, 7) == 0) a = 32'h80;
      issue(1, op, a, rt, imm, src, $urandom_range(0, 7));
    end

    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (q32.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d operations never completed, expected 0", q32.size() + q8.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
